// File: rtl/dot_product_if.sv
// Handshake bundle for dot_product_seq: operand pair in, match count out.
// master = producer/consumer side, slave = the dot-product engine.
interface dot_product_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] vector_a;
  logic [31:0] vector_b;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  result;
  logic        busy;

  modport master (
    output in_valid, vector_a, vector_b, out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  in_valid, vector_a, vector_b, out_ready,
    output in_ready, out_valid, result, busy
  );
endinterface

// File: rtl/dot_product_seq.sv
// Bit-serial binary dot product: counts positions where both 32-bit vectors are 1.
// Define DOT_PRODUCT_EARLY_EXIT_EN to finish as soon as no remaining bit pair can match.
module dot_product_seq (
  input  logic          clk,
  input  logic          rst_n,
  dot_product_if.slave  bus
);

  localparam int unsigned VEC_W = 32;
  localparam int unsigned RES_W = 6;
  localparam int unsigned IDX_W = 5;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q,     state_d;
  logic [VEC_W-1:0] sh_a_q,      sh_a_d;
  logic [VEC_W-1:0] sh_b_q,      sh_b_d;
  logic [RES_W-1:0] acc_q,       acc_d;
  logic [IDX_W-1:0] idx_q,       idx_d;
  logic [RES_W-1:0] result_q,    result_d;
  logic             in_ready_q,  in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q,      busy_d;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      sh_a_q      <= '0;
      sh_b_q      <= '0;
      acc_q       <= '0;
      idx_q       <= '0;
      result_q    <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sh_a_q      <= sh_a_d;
      sh_b_q      <= sh_b_d;
      acc_q       <= acc_d;
      idx_q       <= idx_d;
      result_q    <= result_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state and next-output logic; status flags are computed one edge ahead
  always_comb begin
    state_d     = state_q;
    sh_a_d      = sh_a_q;
    sh_b_d      = sh_b_q;
    acc_d       = acc_q;
    idx_d       = idx_q;
    result_d    = result_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;

    case (state_q)
      S_IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          sh_a_d     = bus.vector_a;
          sh_b_d     = bus.vector_b;
          acc_d      = '0;
          idx_d      = '0;
          state_d    = S_RUN;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
        end
      end

      S_RUN: begin
`ifdef DOT_PRODUCT_EARLY_EXIT_EN
        if ((sh_a_q & sh_b_q) == '0) begin
          state_d     = S_DONE;
          result_d    = acc_q;
          out_valid_d = 1'b1;
        end else
`endif
        begin
          acc_d  = acc_q + RES_W'(sh_a_q[0] & sh_b_q[0]);
          sh_a_d = sh_a_q >> 1;
          sh_b_d = sh_b_q >> 1;
          idx_d  = idx_q + IDX_W'(1);
          if (idx_q == IDX_W'(VEC_W - 1)) begin
            state_d     = S_DONE;
            result_d    = acc_d;
            out_valid_d = 1'b1;
          end
        end
      end

      S_DONE: begin
        // No same-cycle re-accept: in_ready only returns once IDLE is reached
        if (bus.out_ready) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
          busy_d      = 1'b0;
          in_ready_d  = 1'b1;
        end
      end

      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
        in_ready_d  = 1'b1;
      end
    endcase
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_dot_product_seq.sv
// Self-checking bench for dot_product_seq: directed corner pairs plus random pairs
// against a popcount reference; latency counted from the cycle the pair is offered.
module tb_dot_product_seq;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fails;
  int unsigned cyc;
  int unsigned last_accept;

  dot_product_if bus ();

  dot_product_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // Reference: number of positions where both vectors are 1
  function automatic int ref_count(input logic [31:0] a, input logic [31:0] b);
    return $countones(a & b);
  endfunction

  // Reference latency: cycles from the offer cycle (1) to the first cycle out_valid is seen
  function automatic int ref_latency(input logic [31:0] a, input logic [31:0] b);
`ifdef DOT_PRODUCT_EARLY_EXIT_EN
    int m;
    int l;
    logic [31:0] both;
    both = a & b;
    m = -1;
    for (int i = 0; i < 32; i++) if (both[i]) m = i;
    l = m + 2;
    if (l > 32) l = 32;
    return l + 1;
`else
    return 33;
`endif
  endfunction

  // Offer one pair, wait for the result, optionally stall the consumer, then drain.
  // Called and returns positioned just after a falling edge.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input int hold, input bit noise);
    int lat;
    logic [5:0] exp_res;
    exp_res = 6'(ref_count(a, b));
    chk("in_ready_before_accept", 32'(bus.in_ready), 32'd1);
    bus.out_ready = (hold == 0);
    bus.in_valid  = 1'b1;
    bus.vector_a  = a;
    bus.vector_b  = b;
    @(posedge clk);
    @(negedge clk);
    last_accept  = cyc;
    bus.in_valid = 1'b0;
    if (noise) begin
      bus.vector_a = $urandom;
      bus.vector_b = $urandom;
    end
    chk("busy_after_accept", 32'(bus.busy), 32'd1);
    chk("in_ready_after_accept", 32'(bus.in_ready), 32'd0);
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 100) begin
      if (noise) begin
        bus.in_valid = 1'($urandom_range(0, 1));
        bus.vector_a = $urandom;
        bus.vector_b = $urandom;
      end
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    bus.in_valid = 1'b0;
    chk("latency", 32'(lat), 32'(ref_latency(a, b)));
    chk("result", 32'(bus.result), 32'(exp_res));
    chk("busy_in_done", 32'(bus.busy), 32'd1);
    for (int h = 0; h < hold; h++) begin
      bus.in_valid = 1'(h % 2);
      bus.vector_a = ~a;
      bus.vector_b = ~b;
      @(posedge clk);
      @(negedge clk);
      chk("out_valid_held", 32'(bus.out_valid), 32'd1);
      chk("result_held", 32'(bus.result), 32'(exp_res));
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("out_valid_one_cycle", 32'(bus.out_valid), 32'd0);
    chk("in_ready_after_take", 32'(bus.in_ready), 32'd1);
    chk("busy_after_take", 32'(bus.busy), 32'd0);
    chk("result_kept_idle", 32'(bus.result), 32'(exp_res));
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    int unsigned t_first;
    n_checks = 0;
    n_fails  = 0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.vector_a  = '0;
    bus.vector_b  = '0;
    rst_n = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_result", 32'(bus.result), 32'd0);
    rst_n = 1'b1;

    // Directed corner pairs (first accept on the first edge after reset release)
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1);
    run_op(32'hAAAA_AAAA, 32'h5555_5555, 0, 1);
    run_op(32'h0000_000F, 32'h0000_00FF, 10, 0);
    run_op(32'h8000_0001, 32'h8000_0001, 0, 0);

    // Back-to-back pairs with the consumer always ready
    ra = $urandom | 32'h8000_0000;
    rb = $urandom | 32'h8000_0000;
    run_op(ra, rb, 0, 0);
    t_first = last_accept;
    ra = $urandom | 32'h8000_0000;
    rb = $urandom | 32'h8000_0000;
    run_op(ra, rb, 0, 0);
    chk("accept_spacing", last_accept - t_first, 32'd34);

    // Random pairs, some sparse so early termination gets exercised
    for (int k = 0; k < 10; k++) begin
      ra = $urandom;
      rb = $urandom & ($urandom >> $urandom_range(0, 31));
      if (k % 4 == 3) rb = '0;
      run_op(ra, rb, int'($urandom_range(0, 3)), 1);
    end

    // Reset in the middle of RUN aborts the operation
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.vector_a  = 32'hFFFF_FFFF;
    bus.vector_b  = 32'h8000_00FF;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_in_ready", 32'(bus.in_ready), 32'd1);
    chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_result", 32'(bus.result), 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("abort_no_out_valid", 32'(bus.out_valid), 32'd0);
    end
    rst_n = 1'b1;
    run_op(32'h0000_0003, 32'h0000_0001, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
